// File: rtl/stage_memory_if.sv
// -----------------------------------------------------------------------------
// stage_memory_if
// Data-memory bus between the Osiris I memory-access stage and the data memory.
// The request side holds the request, direction, byte enables, address and
// write data. The response side returns the grant, the read-valid strobe and
// the read word.
//
// Signals:
//   dmem_req     master -> slave  bus request
//   dmem_we      master -> slave  write enable
//   dmem_be      master -> slave  byte enables (one per lane)
//   dmem_addr    master -> slave  word-aligned byte address
//   dmem_wdata   master -> slave  lane-replicated store data
//   dmem_gnt     slave -> master  request accepted this cycle
//   dmem_rvalid  slave -> master  read data valid
//   dmem_rdata   slave -> master  read word
// -----------------------------------------------------------------------------
interface stage_memory_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  dmem_req;
  logic                  dmem_we;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
// Memory-access (M) stage of the Osiris I pipeline. It takes the address and
// the store data from the EX/M register and runs one data-memory transaction
// per load/store. It handles byte/half/word lane steering and load extension,
// and it stalls the pipeline until the access completes.
//
// Configuration macro: MEM_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses are flagged and issue no request
//   undefined -> o_misaligned_M = 0; the address bits covered by the access
//                size are ignored, so every access is handled as aligned
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid_M          M slot holds a real instruction
//   i_mem_read_M       load
//   i_mem_write_M      store (wins if both are set)
//   i_funct3_M         size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_alu_result_M     byte address
//   i_write_data_M     store data (low bytes used)
//   o_read_data_M      extended load result; holds until the next load completes
//   o_stall_M          freezes IF/ID/EX/M and the pipeline registers
//   o_misaligned_M     misaligned access presented in IDLE
//   dmem               data-memory bus (master side)
// -----------------------------------------------------------------------------
module stage_memory #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_M,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_misaligned_M,
  stage_memory_if.master        dmem
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t                r_state;
  logic                  r_req;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_access;
  logic                  w_zext;
  size_t                 w_size;
  logic [DATA_WIDTH-1:0] w_addr_eff;
  logic [1:0]            w_off;
  logic                  w_misaligned;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_access = i_valid_M & (i_mem_read_M | i_mem_write_M);
  assign w_zext   = i_funct3_M[2];

  // funct3[1] set means word, which also covers the unsupported 011/110/111.
  assign w_size = i_funct3_M[1] ? SZ_W : (i_funct3_M[0] ? SZ_H : SZ_B);

  // Steering address: the bits below the access size are cleared. With the
  // check enabled, misaligned accesses never issue, so the mask only changes
  // behaviour when the check is disabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_addr_eff = i_alu_result_M;
    case (w_size)
      SZ_H:    w_addr_eff[0]   = 1'b0;
      SZ_W:    w_addr_eff[1:0] = 2'b00;
      default: ;
    endcase
  end

  assign w_off = w_addr_eff[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misaligned = ((w_size == SZ_H) &  i_alu_result_M[0])
                      | ((w_size == SZ_W) & (i_alu_result_M[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Store lane steering and byte enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_write_data_M;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_write_data_M[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{i_write_data_M[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  // The M-stage inputs stay stable while stalled, so the live size/offset
  // still describe the access in flight when the read word arrives.
  assign w_shifted = dmem.dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = dmem.dmem_rdata;
    case (w_size)
      SZ_B: w_load = {{(DATA_WIDTH-8){~w_zext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: w_load = {{(DATA_WIDTH-16){~w_zext & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: all state is reset here; there is no memory array, so nothing is left uninitialised.
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_misaligned) begin
            r_req   <= 1'b1;
            r_we    <= i_mem_write_M;
            r_be    <= w_be;
            r_addr  <= {w_addr_eff[DATA_WIDTH-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem.dmem_gnt) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_state <= ST_DONE;
            end else if (dmem.dmem_rvalid) begin
              r_rdata <= w_load;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            r_rdata <= w_load;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The IDLE term is combinational so the stall is raised in the very cycle
  // the access is first presented.
  assign o_stall_M = ((r_state == ST_IDLE) & w_access & ~w_misaligned)
                   | (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign o_misaligned_M = (r_state == ST_IDLE) & w_access & w_misaligned;
  assign o_read_data_M  = r_rdata;

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

endmodule

// File: tb/tb_stage_memory.sv
// -----------------------------------------------------------------------------
// tb_stage_memory
// Self-checking bench for stage_memory. A bench-side bus responder returns
// gnt/rvalid after programmable delays. Expected load results are pushed to a
// scoreboard queue when the access is driven, and they are popped when the
// stage completes the access.
// -----------------------------------------------------------------------------
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [31:0] read_data_m;
  logic        stall_m, misaligned_m;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 32'h0;

  stage_memory_if #(.DATA_WIDTH(32)) dmem_bus ();

  stage_memory #(.DATA_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid_M      (valid_m),
    .i_mem_read_M   (mem_read_m),
    .i_mem_write_M  (mem_write_m),
    .i_funct3_M     (funct3_m),
    .i_alu_result_M (alu_result_m),
    .i_write_data_M (write_data_m),
    .o_read_data_M  (read_data_m),
    .o_stall_M      (stall_m),
    .o_misaligned_M (misaligned_m),
    .dmem           (dmem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] m_addr_eff(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1])      return {a[31:2], 2'b00};
    else if (f3[0]) return {a[31:1], 1'b0};
    else            return a;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] ea = m_addr_eff(f3, a);
    if (f3[1]) return 4'b1111;
    if (f3[0]) return ea[1] ? 4'b1100 : 4'b0011;
    case (ea[1:0])
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1]) return d;
    if (f3[0]) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] ea = m_addr_eff(f3, a);
    logic [15:0] h;
    logic [7:0]  b;
    if (f3[1]) return rd;
    if (f3[0]) begin
      h = ea[1] ? rd[31:16] : rd[15:0];
      return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
    end
    case (ea[1:0])
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  // Runs one aligned access. Called and returns at posedge+1.
  // gnt arrives gnt_dly cycles after the first REQ cycle; rvalid arrives
  // rv_dly cycles after gnt (0 = same cycle).
  task automatic run_access(input string tag, input logic wr, input logic rd_too,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input logic [31:0] exp_rd, input int gnt_dly, input int rv_dly);
    int          stalls = 0;
    bit          done = 0;
    logic [31:0] ea = m_addr_eff(f3, a);
    valid_m      = 1'b1;
    mem_read_m   = ~wr | rd_too;
    mem_write_m  = wr;
    funct3_m     = f3;
    alu_result_m = a;
    write_data_m = wd;
    if (!wr) sb_q.push_back(exp_rd);
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_bus.dmem_gnt    = (c == 1 + gnt_dly);
      dmem_bus.dmem_rvalid = !wr && (c == 1 + gnt_dly + rv_dly);
      dmem_bus.dmem_rdata  = dmem_bus.dmem_rvalid ? rd : 32'hBAD0_BAD0;
      @(negedge clk);
      if (c == 0) check({tag, "_stall_idle"}, 32'(stall_m), 32'd1);
      if (c == 1) begin
        check({tag, "_req"},  32'(dmem_bus.dmem_req), 32'd1);
        check({tag, "_we"},   32'(dmem_bus.dmem_we), 32'(wr));
        check({tag, "_be"},   32'(dmem_bus.dmem_be), 32'(m_be(f3, a)));
        check({tag, "_addr"}, dmem_bus.dmem_addr, {ea[31:2], 2'b00});
        if (wr) check({tag, "_wdata"}, dmem_bus.dmem_wdata, m_wdata(f3, wd));
      end
      if (stall_m) stalls++;
      else if (c > 0) begin
        done = 1;
        check({tag, "_req_done"}, 32'(dmem_bus.dmem_req), 32'd0);
      end
      @(posedge clk); #1;
    end
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    valid_m              = 1'b0;
    check({tag, "_completed"}, 32'(done), 32'd1);
    if (done) check({tag, "_stall_cycles"}, 32'(stalls), 32'(2 + gnt_dly + (wr ? 0 : rv_dly)));
    @(negedge clk);
    if (wr) begin
      check({tag, "_rdata_hold"}, read_data_m, last_rd);
    end else if (sb_q.size() > 0) begin
      last_rd = sb_q.pop_front();
      check({tag, "_rdata"}, read_data_m, last_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] a, rd;

    rst_n = 1'b0;
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
    funct3_m = 3'b0; alu_result_m = '0; write_data_m = '0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   32'(dmem_bus.dmem_req), 32'd0);
    check("rst_we",    32'(dmem_bus.dmem_we), 32'd0);
    check("rst_be",    32'(dmem_bus.dmem_be), 32'd0);
    check("rst_addr",  dmem_bus.dmem_addr, 32'd0);
    check("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("rst_rdata", read_data_m, 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_mis",   32'(misaligned_m), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores
    run_access("sw100", 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, '0, '0, 0, 0);
    run_access("sb103", 1, 0, 3'b000, 32'h103, 32'h000000A5, '0, '0, 1, 0);
    run_access("sh102", 1, 0, 3'b001, 32'h102, 32'hCAFE1234, '0, '0, 2, 0);
    run_access("wr_pri", 1, 1, 3'b010, 32'h300, 32'h0BADF00D, '0, '0, 0, 0);

    // Loads
    run_access("lh102",  0, 0, 3'b001, 32'h102, '0, 32'h80011234, 32'hFFFF8001, 0, 2);
    run_access("lhu102", 0, 0, 3'b101, 32'h102, '0, 32'h80011234, 32'h00008001, 1, 1);
    run_access("lb101",  0, 0, 3'b000, 32'h101, '0, 32'h00007F00, 32'h0000007F, 0, 0);
    run_access("lb103",  0, 0, 3'b000, 32'h103, '0, 32'h80000000, 32'hFFFFFF80, 0, 1);
    run_access("lbu103", 0, 0, 3'b100, 32'h103, '0, 32'h80000000, 32'h00000080, 1, 0);
    run_access("lb102",  0, 0, 3'b000, 32'h102, '0, 32'h00550000, 32'h00000055, 0, 0);
    run_access("lh100",  0, 0, 3'b001, 32'h100, '0, 32'h1234ABCD, 32'hFFFFABCD, 0, 0);
    run_access("lhu100", 0, 0, 3'b101, 32'h100, '0, 32'h1234ABCD, 32'h0000ABCD, 0, 0);
    run_access("lw200",  0, 0, 3'b010, 32'h200, '0, 32'h89ABCDEF, 32'h89ABCDEF, 3, 1);
    run_access("lw_f011", 0, 0, 3'b011, 32'h204, '0, 32'h13579BDF, 32'h13579BDF, 0, 0);
    run_access("sb_hold", 1, 0, 3'b000, 32'h001, 32'h00000077, '0, '0, 0, 0);

    // Misaligned word load
`ifdef MEM_MISALIGN_CHECK_EN
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
    funct3_m = 3'b010; alu_result_m = 32'h102;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_flag",  32'(misaligned_m), 32'd1);
      check("mis_stall", 32'(stall_m), 32'd0);
      check("mis_req",   32'(dmem_bus.dmem_req), 32'd0);
      @(posedge clk); #1;
    end
    valid_m = 1'b0;
    @(negedge clk);
    check("mis_clear", 32'(misaligned_m), 32'd0);
    @(posedge clk); #1;
`else
    run_access("lw102_na", 0, 0, 3'b010, 32'h102, '0, 32'hA1B2C3D4, 32'hA1B2C3D4, 0, 0);
    run_access("lh101_na", 0, 0, 3'b001, 32'h101, '0, 32'h0000F00F, 32'hFFFFF00F, 0, 0);
`endif

    // Random aligned loads
    for (int i = 0; i < 8; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = $urandom() & 32'h0000_0FFF;
      a  = m_addr_eff(f3, a);
      rd = $urandom();
      run_access("rnd_ld", 0, 0, f3, a, '0, rd, m_load(f3, a, rd),
                 $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Spurious gnt/rvalid with no access in flight
    dmem_bus.dmem_gnt = 1'b1; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      check("spur_req",   32'(dmem_bus.dmem_req), 32'd0);
      check("spur_rdata", read_data_m, last_rd);
      @(posedge clk); #1;
    end
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;

    // Reset while waiting for rvalid, then a late rvalid
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
    funct3_m = 3'b010; alu_result_m = 32'h400;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(stall_m), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_req",   32'(dmem_bus.dmem_req), 32'd0);
    check("rstw_rdata", read_data_m, 32'd0);
    valid_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      check("late_rdata", read_data_m, 32'd0);
      check("late_stall", 32'(stall_m), 32'd0);
      check("late_req",   32'(dmem_bus.dmem_req), 32'd0);
      @(posedge clk); #1;
    end
    dmem_bus.dmem_rvalid = 1'b0;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
